// File: rtl/gray_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer, with change pulse and arm tracking.
// Define GRAY_PTR_SYNC_CHECK_EN to add the sticky multi-bit step error detector.
module gray_ptr_sync #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] gray_i,
  input  logic             err_clr_i,
  output logic [CNT_W-1:0] gray_o,
  output logic             chg_o,
  output logic             armed_o,
  output logic             err_o
);
  localparam int ARM_W = $clog2(SYNC_STAGES + 1);

  logic [CNT_W-1:0] r_sync [SYNC_STAGES];
  logic [ARM_W-1:0] r_arm_cnt;
  logic             r_armed;
  logic             r_chg;
  logic [CNT_W-1:0] w_diff;

  // s[0] samples the foreign-domain pointer directly; no logic in front of it
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Arms once the whole chain has been refilled with post-reset samples
  always_ff @(posedge clk) begin
    if (reset) begin
      r_arm_cnt <= '0;
      r_armed   <= 1'b0;
    end else begin
      if (r_arm_cnt != ARM_W'(SYNC_STAGES)) r_arm_cnt <= r_arm_cnt + 1'b1;
      if (r_arm_cnt == ARM_W'(SYNC_STAGES)) r_armed <= 1'b1;
    end
  end

  assign w_diff = r_sync[SYNC_STAGES-2] ^ r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) r_chg <= 1'b0;
    else       r_chg <= (|w_diff) && r_armed;
  end

  assign gray_o  = r_sync[SYNC_STAGES-1];
  assign chg_o   = r_chg;
  assign armed_o = r_armed;

`ifdef GRAY_PTR_SYNC_CHECK_EN
  localparam int PC_W = $clog2(CNT_W + 1);

  logic [PC_W-1:0] w_popcnt;
  logic            w_illegal;
  logic            r_bad;
  logic            r_err;

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < CNT_W; i++) w_popcnt = w_popcnt + PC_W'(w_diff[i]);
  end

  assign w_illegal = (w_popcnt > PC_W'(1));

  // Illegal step is registered alongside gray_o, so the flag lands one cycle later;
  // a pending set always beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bad <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_bad <= w_illegal && r_armed;
      r_err <= r_bad | (r_err & ~err_clr_i);
    end
  end

  assign err_o = r_err;
`else
  logic w_unused_clr;
  assign w_unused_clr = err_clr_i;
  assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Bench for gray_ptr_sync (CNT_W=4, SYNC_STAGES=2): per-cycle reference model plus
// directed hand-computed checks; error expectations follow GRAY_PTR_SYNC_CHECK_EN.
module tb_gray_ptr_sync;
  localparam int W = 4;
  localparam int S = 2;
`ifdef GRAY_PTR_SYNC_CHECK_EN
  localparam int CHECK = 1;
`else
  localparam int CHECK = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         err_clr_i;
  logic [W-1:0] gray_i;
  logic [W-1:0] gray_o;
  logic         chg_o;
  logic         armed_o;
  logic         err_o;

  int n_checks = 0;
  int n_fail   = 0;

  gray_ptr_sync #(.CNT_W(W), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .gray_i    (gray_i),
    .err_clr_i (err_clr_i),
    .gray_o    (gray_o),
    .chg_o     (chg_o),
    .armed_o   (armed_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic dchk(input string name, input int act, input int exp);
    chk(name, act, exp);
    $display("check %-12s got %0d exp %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: output = input seen S edges earlier once the chain is refilled,
  // armed after S+1 clean edges, pulses/errors judged on consecutive gray_o values.
  initial begin : model
    int since, valid;
    int hist [S];
    int m_gray, m_arm, m_chg, m_bad, m_err;
    int p_gray, p_arm, p_bad, p_err;
    int r, g, c;
    since = 0; valid = 0;
    m_gray = 0; m_arm = 0; m_chg = 0; m_bad = 0; m_err = 0;
    foreach (hist[i]) hist[i] = 0;
    forever begin
      @(posedge clk);
      r = int'(reset); g = int'(gray_i); c = int'(err_clr_i);
      #1;
      if (r != 0) begin
        since = 0;
        foreach (hist[i]) hist[i] = 0;
        m_gray = 0; m_arm = 0; m_chg = 0; m_bad = 0; m_err = 0;
        valid = 1;
      end else begin
        p_gray = m_gray; p_arm = m_arm; p_bad = m_bad; p_err = m_err;
        if (since < 100) since++;
        for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = g;
        m_gray = (since >= S) ? hist[S-1] : 0;
        m_arm  = (since >= S + 1) ? 1 : 0;
        m_chg  = (p_arm != 0 && m_gray != p_gray) ? 1 : 0;
        m_bad  = (CHECK != 0 && p_arm != 0 && $countones(m_gray ^ p_gray) > 1) ? 1 : 0;
        m_err  = (CHECK != 0 && (p_bad != 0 || (p_err != 0 && c == 0))) ? 1 : 0;
      end
      if (valid != 0) begin
        chk("m_gray_o",  int'(gray_o),  m_gray);
        chk("m_chg_o",   int'(chg_o),   m_chg);
        chk("m_armed_o", int'(armed_o), m_arm);
        chk("m_err_o",   int'(err_o),   m_err);
      end
    end
  end

  initial begin : stim
    int pulses, errs, k;
    reset = 1'b1; gray_i = '0; err_clr_i = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // arm sequence with a zero pointer
    @(negedge clk); dchk("armed_c1", int'(armed_o), 0);
    @(negedge clk); dchk("armed_c2", int'(armed_o), 0);
    @(negedge clk); dchk("armed_c3", int'(armed_o), 1);
    dchk("chg_idle", int'(chg_o), 0);
    dchk("err_idle", int'(err_o), 0);
    repeat (2) @(negedge clk);

    // 0000 -> 0001 latency and single pulse
    gray_i = 4'b0001;
    @(negedge clk); dchk("lat_gray1", int'(gray_o), 0); dchk("lat_chg1", int'(chg_o), 0);
    @(negedge clk); dchk("lat_gray2", int'(gray_o), 1); dchk("lat_chg2", int'(chg_o), 1);
    @(negedge clk); dchk("lat_gray3", int'(gray_o), 1); dchk("lat_chg3", int'(chg_o), 0);

    // full Gray walk including the 1000 -> 0000 wrap
    pulses = 0; errs = 0;
    for (int i = 2; i <= 17; i++) begin
      k = i % 16;
      gray_i = W'(k ^ (k >> 1));
      @(negedge clk);
      pulses += int'(chg_o); errs += int'(err_o);
    end
    repeat (4) begin
      @(negedge clk);
      pulses += int'(chg_o); errs += int'(err_o);
    end
    dchk("walk_pulses", pulses, 16);
    dchk("walk_errs", errs, 0);
    dchk("walk_gray", int'(gray_o), 1);

    // illegal jump 0000 -> 0011
    gray_i = 4'b0000;
    repeat (4) @(negedge clk);
    gray_i = 4'b0011;
    @(negedge clk); dchk("jmp_gray1", int'(gray_o), 0);
    @(negedge clk); dchk("jmp_gray2", int'(gray_o), 3); dchk("jmp_err2", int'(err_o), 0);
    @(negedge clk); dchk("jmp_err3", int'(err_o), CHECK);
    repeat (3) @(negedge clk);
    dchk("jmp_hold", int'(err_o), CHECK);
    err_clr_i = 1'b1;
    @(negedge clk); err_clr_i = 1'b0;
    dchk("jmp_clr", int'(err_o), 0);
    @(negedge clk); dchk("jmp_clr2", int'(err_o), 0);

    // illegal 0011 -> 0000 while clear is held: set wins
    gray_i = 4'b0000;
    @(negedge clk); err_clr_i = 1'b1;
    @(negedge clk);
    @(negedge clk); err_clr_i = 1'b0;
    dchk("coin_err", int'(err_o), CHECK);

    // reset in the middle of a walk
    gray_i = 4'b0001; @(negedge clk);
    gray_i = 4'b0011; @(negedge clk);
    gray_i = 4'b0010; @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    dchk("rst_gray", int'(gray_o), 0);
    dchk("rst_chg", int'(chg_o), 0);
    dchk("rst_armed", int'(armed_o), 0);
    dchk("rst_err", int'(err_o), 0);
    reset = 1'b0;
    @(negedge clk); dchk("rearm_c1", int'(armed_o), 0);
    @(negedge clk); dchk("rearm_c2", int'(armed_o), 0); dchk("rearm_gray", int'(gray_o), 2);
    dchk("rearm_chg", int'(chg_o), 0);
    @(negedge clk); dchk("rearm_c3", int'(armed_o), 1);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
